// File: rtl/serial_tx_pkg.sv
// ============================================================================
// serial_tx_pkg : shared link definitions (opcodes, frame size, tx states)
// Revision      : 1.0
// ============================================================================
`default_nettype none

package serial_tx_pkg;

    // Opcodes shared with the receiving end of the link.
    localparam logic [3:0] OP_RECEIVE_VALID_MOVE = 4'h1;
    localparam logic [3:0] OP_INVALID_MOVE       = 4'h2;
    localparam logic [3:0] OP_GAME_OVER          = 4'h3;
    localparam logic [3:0] OP_ACK                = 4'h4;

    localparam int FRAME_BITS = 17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    // Odd-parity frame: the trailer makes the total count of ones odd.
    function automatic logic [FRAME_BITS-1:0] make_frame(input logic [3:0]  op,
                                                         input logic [11:0] pl);
        return {op, pl, ~^{op, pl}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_tick.sv
// ============================================================================
// serial_tx_tick : half link-clock period tick, phase-cleared on frame accept
// Revision       : 1.0
// ============================================================================
`default_nettype none

module serial_tx_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int             c_W      = $clog2(CLK_DIV) + 1;
    localparam logic [c_W-1:0] c_RELOAD = c_W'(CLK_DIV - 1);
    localparam logic [c_W-1:0] c_ONE    = c_W'(1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_count <= c_RELOAD;
        end else if (r_count == '0) begin
            r_count <= c_RELOAD;
        end else begin
            r_count <= r_count - c_ONE;
        end
    end

    assign tick      = (r_count == '0);
    // One cycle ahead of tick, so registered outputs can land on the tick cycle.
    assign tick_next = (r_count == c_ONE);

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// serial_tx : bit-serial MSB-first command transmitter with odd parity + gap
// Revision  : 1.0
// ============================================================================
`default_nettype none

module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int GAP_BITS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send_valid,
    output logic        send_ready,
    input  logic [3:0]  opcode,
    input  logic [11:0] payload,
    output logic        data_out,
    output logic        clock_out,
    output logic        frame_done
);

    localparam int              c_GAP_HALVES = 2 * GAP_BITS;
    localparam int              c_GW         = $clog2(c_GAP_HALVES) + 1;
    localparam logic [c_GW-1:0] c_GAP_LAST   = c_GW'(c_GAP_HALVES - 1);
    localparam logic [4:0]      c_LAST_BIT   = 5'(FRAME_BITS - 1);

    tx_state_t             r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_bit_cnt;
    logic [c_GW-1:0]       r_gap_cnt;

    logic w_accept;
    logic w_tick;
    logic w_tick_next;

    assign w_accept = send_valid && send_ready && (r_state == ST_IDLE);

    serial_tx_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock     (clock),
        .reset     (reset),
        .clear     (w_accept),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_gap_cnt  <= '0;
            send_ready <= 1'b1;
            data_out   <= 1'b0;
            clock_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= make_frame(opcode, payload);
                        r_bit_cnt  <= '0;
                        data_out   <= opcode[3];
                        send_ready <= 1'b0;
                        r_state    <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_tick) begin
                        clock_out <= 1'b1;
                        r_state   <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    // Data only moves on the falling edge of the link clock.
                    if (w_tick) begin
                        clock_out <= 1'b0;
                        if (r_bit_cnt == c_LAST_BIT) begin
                            data_out  <= 1'b0;
                            r_gap_cnt <= '0;
                            r_state   <= ST_GAP;
                        end else begin
                            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
                            data_out  <= r_shift[FRAME_BITS-2];
                            r_bit_cnt <= r_bit_cnt + 5'd1;
                            r_state   <= ST_LOW;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_tick_next && (r_gap_cnt == c_GAP_LAST)) begin
                        frame_done <= 1'b1;
                    end
                    if (w_tick) begin
                        if (r_gap_cnt == c_GAP_LAST) begin
                            send_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// tb_serial_tx : directed vector bench for serial_tx (CLK_DIV=4, GAP_BITS=4)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_serial_tx;

    logic        clock;
    logic        reset;
    logic        send_valid;
    logic        send_ready;
    logic [3:0]  opcode;
    logic [11:0] payload;
    logic        data_out;
    logic        clock_out;
    logic        frame_done;

    int total;
    int bad;

    serial_tx #(
        .CLK_DIV  (4),
        .GAP_BITS (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .send_valid (send_valid),
        .send_ready (send_ready),
        .opcode     (opcode),
        .payload    (payload),
        .data_out   (data_out),
        .clock_out  (clock_out),
        .frame_done (frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; the following rising edge is the accept edge t.
    // Iteration k observes the registered outputs of cycle t+k.
    task automatic send_frame(input logic [3:0] op, input logic [11:0] pl,
                              input logic par, input bit jitter);
        logic [16:0] exp_bits;
        logic [16:0] got;
        int rises, first_rise, done_k, done_cnt, ready_k, viol, gap_hi;
        logic pc, pd;
        exp_bits   = {op, pl, par};
        got        = '0;
        rises      = 0;
        first_rise = 0;
        done_k     = 0;
        done_cnt   = 0;
        ready_k    = 0;
        viol       = 0;
        gap_hi     = 0;
        chk("ready_before_accept", 32'(send_ready), 32'd1);
        send_valid = 1'b1;
        opcode     = op;
        payload    = pl;
        pc = clock_out;
        pd = data_out;
        for (int k = 1; k <= 169; k++) begin
            @(negedge clock);
            if (k == 1) begin
                chk("ready_drop", 32'(send_ready), 32'd0);
                chk("first_bit", 32'(data_out), 32'(op[3]));
            end
            if (clock_out && !pc) begin
                if (rises < 17) got[16-rises] = data_out;
                rises++;
                if (first_rise == 0) first_rise = k;
            end
            if (clock_out && (data_out !== pd)) viol++;
            if (frame_done) begin
                done_cnt++;
                if (done_k == 0) done_k = k;
            end
            if (send_ready && ready_k == 0) ready_k = k;
            if (k >= 137 && k <= 168 && clock_out) gap_hi++;
            pc = clock_out;
            pd = data_out;
            if (k == 169) begin
                send_valid = 1'b0;
            end else if (jitter) begin
                send_valid = 1'($urandom_range(0, 1));
                opcode     = 4'($urandom);
                payload    = 12'($urandom);
            end else if (k == 1) begin
                send_valid = 1'b0;
            end
        end
        chk("frame_bits", 32'(got), 32'(exp_bits));
        chk("rise_count", 32'(rises), 32'd17);
        chk("first_rise", 32'(first_rise), 32'd5);
        chk("done_cycle", 32'(done_k), 32'd168);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("ready_return", 32'(ready_k), 32'd169);
        chk("data_change_clk_high", 32'(viol), 32'd0);
        chk("gap_clock_high", 32'(gap_hi), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [11:0] pl;
        logic        par;
        bit          jitter;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int idle_viol;
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        send_valid = 1'b0;
        opcode     = '0;
        payload    = '0;

        // Parity bits hand-computed: odd total count of ones per frame.
        vecs[0] = '{4'h1, 12'h0A5, 1'b0, 1'b0};
        vecs[1] = '{4'hF, 12'hFFF, 1'b1, 1'b0};
        vecs[2] = '{4'h0, 12'h000, 1'b1, 1'b0};
        vecs[3] = '{4'h3, 12'h001, 1'b0, 1'b1};
        vecs[4] = '{4'h4, 12'h800, 1'b1, 1'b0};
        vecs[5] = '{4'h2, 12'h7FF, 1'b1, 1'b1};
        vecs[6] = '{4'hA, 12'h555, 1'b1, 1'b1};
        vecs[7] = '{4'h1, 12'h000, 1'b0, 1'b0};

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset_ready", 32'(send_ready), 32'd1);
        chk("reset_data", 32'(data_out), 32'd0);
        chk("reset_clock_out", 32'(clock_out), 32'd0);
        chk("reset_done", 32'(frame_done), 32'd0);

        idle_viol = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (send_ready !== 1'b1 || data_out !== 1'b0 ||
                clock_out !== 1'b0 || frame_done !== 1'b0) idle_viol++;
        end
        chk("idle_50", 32'(idle_viol), 32'd0);

        // Consecutive calls keep send_valid high: frames go out back to back.
        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].op, vecs[i].pl, vecs[i].par, vecs[i].jitter);
        end

        // Reset sampled at edge t+60 abandons the frame.
        send_valid = 1'b1;
        opcode     = 4'h2;
        payload    = 12'h3C3;
        for (int k = 1; k <= 61; k++) begin
            @(negedge clock);
            if (k == 1) send_valid = 1'b0;
            if (k == 60) reset = 1'b1;
        end
        reset = 1'b0;
        chk("midreset_ready", 32'(send_ready), 32'd1);
        chk("midreset_data", 32'(data_out), 32'd0);
        chk("midreset_clock_out", 32'(clock_out), 32'd0);
        chk("midreset_done", 32'(frame_done), 32'd0);
        @(negedge clock);
        send_frame(4'h4, 12'h123, 1'b0, 1'b0);

        @(negedge clock);
        chk("final_idle_ready", 32'(send_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
